// File: rtl/rr_packet_arbiter_pkg.sv
// Shared types for the round-robin packet arbiter.
package rr_packet_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_packet_arbiter_fixed_priority_arbiter.sv
// Fixed-priority selector: the lowest set request index wins.
module fixed_priority_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               allow_req_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    found_o = allow_req_i & (|req_i);
    idx_o   = '0;
    // Walk downwards so the lowest requesting index is the one left standing.
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin arbiter that locks a grant for the length of a packet,
// then rotates priority to the requester after the finishing owner.
module rr_packet_arbiter
  import rr_packet_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               allow_req_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] last_i,
  input  logic               gnt_ready_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_addr_o,
  output logic               gnt_valid_o,
  output logic               beat_o
);

  localparam int unsigned SUM_W = IDX_W + 1;

  arb_state_e         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_eff;
  logic [IDX_W-1:0]   owner_inc;
  logic [IDX_W-1:0]   fpa_idx;
  logic [IDX_W-1:0]   pick;
  logic [SUM_W-1:0]   pick_sum;
  logic [NUM_REQ-1:0] req_rot;
  logic               found;
  logic               rel;

  assign beat_o = gnt_valid_o & gnt_ready_i & req_i[gnt_addr_o];

  // Release on the owner's last accepted beat or when the owner drops its request.
  always_comb begin
    owner_inc = (gnt_addr_o == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_addr_o + IDX_W'(1);
    rel       = (state == LOCKED) & ((beat_o & last_i[gnt_addr_o]) | ~req_i[gnt_addr_o]);
    ptr_eff   = rel ? owner_inc : ptr;
  end

  // Rotate so that bit 0 of req_rot is the requester at ptr_eff.
  always_comb begin
    req_rot = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      int j;
      j = i + int'(ptr_eff);
      if (j >= int'(NUM_REQ)) j = j - int'(NUM_REQ);
      req_rot[i] = req_i[j];
    end
  end

  fixed_priority_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_fpa (
    .allow_req_i (allow_req_i),
    .req_i       (req_rot),
    .found_o     (found),
    .idx_o       (fpa_idx)
  );

  // Undo the rotation: pick = (fpa_idx + ptr_eff) mod NUM_REQ.
  always_comb begin
    pick_sum = {1'b0, fpa_idx} + {1'b0, ptr_eff};
    if (pick_sum >= SUM_W'(NUM_REQ)) pick_sum = pick_sum - SUM_W'(NUM_REQ);
    pick = pick_sum[IDX_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ptr         <= '0;
      gnt_o       <= '0;
      gnt_addr_o  <= '0;
      gnt_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state       <= LOCKED;
            gnt_addr_o  <= pick;
            gnt_o       <= NUM_REQ'(1) << pick;
            gnt_valid_o <= 1'b1;
          end
        end
        LOCKED: begin
          if (rel) begin
            ptr <= owner_inc;
            if (found) begin
              gnt_addr_o <= pick;
              gnt_o      <= NUM_REQ'(1) << pick;
            end else begin
              state       <= IDLE;
              gnt_o       <= '0;
              gnt_addr_o  <= '0;
              gnt_valid_o <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          gnt_o       <= '0;
          gnt_addr_o  <= '0;
          gnt_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed and random checks of rr_packet_arbiter against a packet-level reference model.
module tb_rr_packet_arbiter;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst, allow, ready;
  logic [NR-1:0] req, last;
  logic [NR-1:0] gnt;
  logic [1:0]    gnt_addr;
  logic          gnt_valid, beat;

  logic       rst3, allow3, ready3;
  logic [2:0] req3, last3, gnt3;
  logic [1:0] gnt_addr3;
  logic       gnt_valid3, beat3;

  int checks   = 0;
  int failures = 0;
  int m_owner  = -1;
  int m_ptr    = 0;

  always #5 clk = ~clk;

  rr_packet_arbiter #(.NUM_REQ(NR)) dut (
    .clk_i(clk), .rst_i(rst), .allow_req_i(allow), .req_i(req), .last_i(last),
    .gnt_ready_i(ready), .gnt_o(gnt), .gnt_addr_o(gnt_addr),
    .gnt_valid_o(gnt_valid), .beat_o(beat)
  );

  rr_packet_arbiter #(.NUM_REQ(3)) dut3 (
    .clk_i(clk), .rst_i(rst3), .allow_req_i(allow3), .req_i(req3), .last_i(last3),
    .gnt_ready_i(ready3), .gnt_o(gnt3), .gnt_addr_o(gnt_addr3),
    .gnt_valid_o(gnt_valid3), .beat_o(beat3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requester at or after p, circularly; -1 if none.
  function automatic int search(input int p, input logic [NR-1:0] q);
    for (int k = 0; k < NR; k++) begin
      if (q[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic model_beat();
    return (m_owner >= 0) && ready && req[m_owner];
  endfunction

  task automatic model_step();
    bit done;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      if (allow) m_owner = search(m_ptr, req);
    end else begin
      done = (model_beat() && last[m_owner]) || !req[m_owner];
      if (done) begin
        m_ptr   = (m_owner + 1) % NR;
        m_owner = allow ? search(m_ptr, req) : -1;
      end
    end
  endtask

  task automatic tick(input logic r, input logic a, input logic [NR-1:0] q,
                      input logic [NR-1:0] l, input logic rdy);
    rst = r; allow = a; req = q; last = l; ready = rdy;
    #1;
    chk("beat", 32'(beat), 32'(model_beat()));
    model_step();
    @(posedge clk); #1;
    chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    chk("gnt_onehot", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    if (m_owner >= 0) chk("gnt_addr", 32'(gnt_addr), 32'(m_owner));
  endtask

  initial begin
    rst = 1'b1; allow = 1'b0; req = '0; last = '0; ready = 1'b0;
    rst3 = 1'b1; allow3 = 1'b0; req3 = '0; last3 = '0; ready3 = 1'b0;
    @(posedge clk); #1;

    // Reset state and first grant with one-cycle latency.
    tick(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("reset_valid", 32'(gnt_valid), 32'd0);
    chk("reset_addr", 32'(gnt_addr), 32'd0);
    tick(1'b0, 1'b1, 4'b0110, 4'b0000, 1'b0);
    chk("first_addr", 32'(gnt_addr), 32'd1);
    chk("first_gnt", 32'(gnt), 32'b0010);

    // Three-beat packet on owner 1, then no-bubble handover to 2.
    tick(1'b0, 1'b1, 4'b0110, 4'b0000, 1'b1);
    tick(1'b0, 1'b1, 4'b0110, 4'b0000, 1'b1);
    tick(1'b0, 1'b1, 4'b0110, 4'b0010, 1'b1);
    chk("handover_addr", 32'(gnt_addr), 32'd2);
    chk("handover_valid", 32'(gnt_valid), 32'd1);

    // last without ready is ignored; abort moves the grant on.
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 4'b0110, 4'b0100, 1'b0);
    chk("stall_hold", 32'(gnt_addr), 32'd2);
    tick(1'b0, 1'b1, 4'b0010, 4'b0100, 1'b0);
    chk("abort_next", 32'(gnt_addr), 32'd1);
    tick(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    chk("abort_idle", 32'(gnt_valid), 32'd0);

    // allow=0 blocks new grants but lets a locked packet finish.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 4'b1000, 4'b0000, 1'b1);
    chk("disallow_idle", 32'(gnt_valid), 32'd0);
    tick(1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0);
    chk("owner0", 32'(gnt_addr), 32'd0);
    tick(1'b0, 1'b0, 4'b1001, 4'b0000, 1'b1);
    tick(1'b0, 1'b0, 4'b1001, 4'b0000, 1'b1);
    chk("disallow_hold", 32'(gnt_valid), 32'd1);
    tick(1'b0, 1'b0, 4'b1001, 4'b0001, 1'b1);
    chk("disallow_release", 32'(gnt_valid), 32'd0);

    // Rotation over single-beat packets: 0,1,2,3,0.
    tick(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
    tick(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0);
    chk("rot0", 32'(gnt_addr), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1);
      chk("rot_seq", 32'(gnt_addr), 32'(i % 4));
    end

    // Reset while locked on 3 clears everything; ptr back to 0.
    tick(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
    tick(1'b0, 1'b1, 4'b1000, 4'b0000, 1'b0);
    chk("lock3", 32'(gnt_addr), 32'd3);
    tick(1'b1, 1'b1, 4'b1000, 4'b0000, 1'b0);
    chk("rst_valid", 32'(gnt_valid), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_addr", 32'(gnt_addr), 32'd0);
    tick(1'b0, 1'b1, 4'b1001, 4'b0000, 1'b0);
    chk("post_rst_addr", 32'(gnt_addr), 32'd0);

    // Randomized traffic checked against the model.
    for (int i = 0; i < 2000; i++) begin
      tick(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 7) != 0),
           4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    // Three-requester wrap: 0,1,2,0.
    rst3 = 1'b0; allow3 = 1'b1; req3 = 3'b111; last3 = 3'b111; ready3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("n3_valid", 32'(gnt_valid3), 32'd1);
      chk("n3_seq", 32'(gnt_addr3), 32'(i % 3));
      chk("n3_gnt", 32'(gnt3), 32'd1 << (i % 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
- Round-robin arbiter with packet locking; shares one downstream port among NUM_REQ requesters.
- A grant is held from the first beat of a packet until its last beat (or an abort), then the grant rotates.
- Sits in front of a shared bus or buffer write port. Uses fixed-priority selection on a rotated request vector.

Parameters:
- NUM_REQ, 4, number of requesters (≥2; non-power-of-2 supported)
- IDX_W, $clog2(NUM_REQ), width of the grant index (derived localparam, not overridable)

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  synchronous, active-high reset
- allow_req_i  in  1  enables new grants; does not affect an already-locked owner
- req_i  in  NUM_REQ  per-requester request, level-held for the whole packet
- last_i  in  NUM_REQ  per-requester end-of-packet flag, sampled only for the owner
- gnt_ready_i  in  1  downstream accepts a beat this cycle
- gnt_o  out  NUM_REQ  one-hot grant, registered
- gnt_addr_o  out  IDX_W  index of the owner, registered
- gnt_valid_o  out  1  a lock is held; gnt_o and gnt_addr_o are valid
- beat_o  out  1  transfer this cycle = gnt_valid_o & gnt_ready_i & req_i[gnt_addr_o]

Behaviour:
- Reset and interface:
  - One clock (clk_i); reset rst_i is synchronous and active-high.
  - While rst_i=1 at an edge: state=IDLE, ptr=0, gnt_o=0, gnt_addr_o=0, gnt_valid_o=0.
  - Reset mid-packet drops the lock immediately; no release is reported.
- States (enum arb_state_e): IDLE, LOCKED.
- Priority pick:
  - Index ptr has highest priority, then ptr+1, … wrapping at NUM_REQ-1→0; ptr-1 is lowest.
  - found = allow_req_i & |req_i.
- IDLE: if found, then next cycle state=LOCKED, gnt_addr_o=pick, gnt_o=1<<pick, gnt_valid_o=1. Grant latency is 1 cycle from req_i to gnt_valid_o.
- LOCKED:
  - Outputs are held stable. beat_o as defined above.
  - If beat_o & last_i[owner] (release), ptr := owner+1 (wrap NUM_REQ-1→0). In the same cycle, re-arbitrate with the new ptr using current req_i and allow_req_i:
    - if found: lock the new owner next cycle. No bubble; the new owner may equal the old one only if no other request exists.
    - else: go to IDLE, gnt_valid_o=0.
  - If req_i[owner]=0 (abort), handle as a release without a beat: ptr advances and re-arbitration is the same as above.
  - last_i of non-owners is ignored. last_i[owner] without gnt_ready_i is ignored.
  - allow_req_i=0 during LOCKED: the current packet completes. Re-arbitration at release sees found=0, so the arbiter goes to IDLE.
- ptr arithmetic: modulo NUM_REQ with an explicit compare against NUM_REQ-1. Never rely on IDX_W overflow.
- Output invariants:
  - gnt_o is one-hot or zero.
  - gnt_o == (gnt_valid_o ? 1<<gnt_addr_o : 0).
  - beat_o is combinational; all other outputs are registered.

Decomposition:
- Shared package (common pkg): arb_state_e {IDLE, LOCKED}.
- One sub-module: the existing fixed_priority_arbiter (NUM_REQ).
  - Input: req_i rotated right by ptr.
  - Output: index, to which ptr is added modulo NUM_REQ to get pick.
  - Its allow_req_i input is driven by the top-level allow_req_i.
- Rotation and modulo-add are local combinational logic in rr_packet_arbiter.

Test Plan:
- Reset, then req_i=4'b0110, allow=1 → 1 cycle later gnt_addr_o=1, gnt_o=4'b0010, gnt_valid_o=1; ptr stays 0 until release.
- Owner 1 sends 3 beats (gnt_ready_i=1, last_i[1] on beat 3), req_i=4'b0110 held → the cycle after beat 3 gives gnt_addr_o=2 with no idle cycle; ptr=2.
- All four requesting continuously, 1-beat packets → grant order 0,1,2,3,0 on consecutive cycles; NUM_REQ=3 variant gives 0,1,2,0 (wrap check).
- Locked on owner 2, gnt_ready_i=0 for 5 cycles with last_i[2]=1 → no release, gnt held; drop req_i[2] → next cycle grant moves to the next requester, or gnt_valid_o=0 if none.
- allow_req_i=0 with req_i=4'b1000 → gnt_valid_o stays 0. Mid-packet on owner 0, allow_req_i=0 → packet completes, then IDLE.
- rst_i pulsed while locked on owner 3 → next cycle all outputs 0, ptr=0; with req_i=4'b1001 the first grant goes to 0.
